kv_table_writer: RTL and testbench

- Sequential owner/writer of a packed key->data lookup table of NR_KEY pairs; drives the flattened `lut` bus consumed by combinational key-match lookup blocks.
- Accepts insert/update/delete commands over a valid/ready handshake and maintains per-entry valid bits.
- Also provides the reverse direction, data->key, as a multi-cycle scanning search with its own request/response handshake.

---
 rtl/kv_table_writer.sv | 186 ++++++++++++++++++
 tb/tb_kv_table_writer.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kv_table_writer.sv
// rtl/kv_table_writer.sv - key->data table owner with insert/update/delete writes and a scanning data->key search
module kv_table_writer #(
  parameter int NR_KEY   = 4,
  parameter int KEY_LEN  = 4,
  parameter int DATA_LEN = 8
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   wr_valid,
  output logic                                   wr_ready,
  input  logic                                   wr_del,
  input  logic [KEY_LEN-1:0]                     wr_key,
  input  logic [DATA_LEN-1:0]                    wr_data,
  output logic                                   wr_err,
  input  logic                                   rev_req_valid,
  output logic                                   rev_req_ready,
  input  logic [DATA_LEN-1:0]                    rev_data,
  output logic                                   rev_resp_valid,
  input  logic                                   rev_resp_ready,
  output logic                                   rev_resp_hit,
  output logic [KEY_LEN-1:0]                     rev_resp_key,
  output logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0]   lut,
  output logic [NR_KEY-1:0]                      entry_valid,
  output logic [$clog2(NR_KEY+1)-1:0]            count,
  output logic                                   full
);

  localparam int ENTRY_W = KEY_LEN + DATA_LEN;
  localparam int IDX_W   = $clog2(NR_KEY);
  localparam int CNT_W   = $clog2(NR_KEY + 1);

  typedef enum logic [1:0] {R_IDLE, R_SCAN, R_DONE} rstate_t;

  logic [KEY_LEN-1:0]  tkey_q  [NR_KEY];
  logic [KEY_LEN-1:0]  tkey_d  [NR_KEY];
  logic [DATA_LEN-1:0] tdata_q [NR_KEY];
  logic [DATA_LEN-1:0] tdata_d [NR_KEY];
  logic [NR_KEY-1:0]   valid_q, valid_d;
  logic                wr_err_q, wr_err_d;
  rstate_t             state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_LEN-1:0] srch_q, srch_d;
  logic                resp_hit_q, resp_hit_d;
  logic [KEY_LEN-1:0]  resp_key_q, resp_key_d;

  logic [CNT_W-1:0]    cnt;
  logic                is_full;
  logic                found, has_free, wr_fire;
  logic [IDX_W-1:0]    found_idx, free_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NR_KEY; i++) begin
        tkey_q[i]  <= '0;
        tdata_q[i] <= '0;
      end
      valid_q    <= '0;
      wr_err_q   <= 1'b0;
      state_q    <= R_IDLE;
      idx_q      <= '0;
      srch_q     <= '0;
      resp_hit_q <= 1'b0;
      resp_key_q <= '0;
    end else begin
      for (int i = 0; i < NR_KEY; i++) begin
        tkey_q[i]  <= tkey_d[i];
        tdata_q[i] <= tdata_d[i];
      end
      valid_q    <= valid_d;
      wr_err_q   <= wr_err_d;
      state_q    <= state_d;
      idx_q      <= idx_d;
      srch_q     <= srch_d;
      resp_hit_q <= resp_hit_d;
      resp_key_q <= resp_key_d;
    end
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < NR_KEY; i++) begin
      cnt = cnt + CNT_W'(valid_q[i]);
    end
    is_full = (cnt == CNT_W'(NR_KEY));
  end

  // Descending scans leave the lowest matching / lowest free index selected.
  always_comb begin
    found     = 1'b0;
    found_idx = '0;
    has_free  = 1'b0;
    free_idx  = '0;
    for (int i = NR_KEY - 1; i >= 0; i--) begin
      if (valid_q[i] && (tkey_q[i] == wr_key)) begin
        found     = 1'b1;
        found_idx = IDX_W'(i);
      end
      if (!valid_q[i]) begin
        has_free = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  assign wr_fire = wr_valid && (state_q == R_IDLE);

  // Write path; vacated slots are zeroed so invalid entries read as key=0/data=0.
  always_comb begin
    for (int i = 0; i < NR_KEY; i++) begin
      tkey_d[i]  = tkey_q[i];
      tdata_d[i] = tdata_q[i];
    end
    valid_d  = valid_q;
    wr_err_d = 1'b0;
    if (wr_fire) begin
      if (wr_del) begin
        if (found) begin
          valid_d[found_idx] = 1'b0;
          tkey_d[found_idx]  = '0;
          tdata_d[found_idx] = '0;
        end
      end else if (found) begin
        tdata_d[found_idx] = wr_data;
      end else if (has_free) begin
        valid_d[free_idx] = 1'b1;
        tkey_d[free_idx]  = wr_key;
        tdata_d[free_idx] = wr_data;
      end else begin
        wr_err_d = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    srch_d     = srch_q;
    resp_hit_d = resp_hit_q;
    resp_key_d = resp_key_q;
    case (state_q)
      R_IDLE: begin
        if (rev_req_valid) begin
          srch_d  = rev_data;
          idx_d   = '0;
          state_d = R_SCAN;
        end
      end
      R_SCAN: begin
        if (valid_q[idx_q] && (tdata_q[idx_q] == srch_q)) begin
          resp_hit_d = 1'b1;
          resp_key_d = tkey_q[idx_q];
          state_d    = R_DONE;
        end else if (idx_q == IDX_W'(NR_KEY - 1)) begin
          resp_hit_d = 1'b0;
          resp_key_d = '0;
          state_d    = R_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      R_DONE: begin
        if (rev_resp_ready) begin
          state_d = R_IDLE;
        end
      end
      default: state_d = R_IDLE;
    endcase
  end

  always_comb begin
    wr_ready       = (state_q == R_IDLE);
    rev_req_ready  = (state_q == R_IDLE);
    rev_resp_valid = (state_q == R_DONE);
    rev_resp_hit   = resp_hit_q;
    rev_resp_key   = resp_key_q;
    wr_err         = wr_err_q;
    entry_valid    = valid_q;
    count          = cnt;
    full           = is_full;
    lut            = '0;
    for (int i = 0; i < NR_KEY; i++) begin
      lut[i*ENTRY_W +: ENTRY_W] = {tkey_q[i], tdata_q[i]};
    end
  end

endmodule

// File: tb/tb_kv_table_writer.sv
// tb/tb_kv_table_writer.sv - randomized self-checking bench for kv_table_writer against an array model
module tb_kv_table_writer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_valid, wr_ready, wr_del, wr_err;
  logic [3:0]  wr_key;
  logic [7:0]  wr_data;
  logic        rev_req_valid, rev_req_ready, rev_resp_valid, rev_resp_ready, rev_resp_hit;
  logic [7:0]  rev_data;
  logic [3:0]  rev_resp_key;
  logic [47:0] lut;
  logic [3:0]  entry_valid;
  logic [2:0]  count;
  logic        full;

  int tests = 0;
  int fails = 0;

  logic [3:0] mkey  [4];
  logic [7:0] mdata [4];
  bit         mval  [4];
  bit         busy_bad;

  kv_table_writer #(.NR_KEY(4), .KEY_LEN(4), .DATA_LEN(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_del(wr_del),
    .wr_key(wr_key), .wr_data(wr_data), .wr_err(wr_err),
    .rev_req_valid(rev_req_valid), .rev_req_ready(rev_req_ready), .rev_data(rev_data),
    .rev_resp_valid(rev_resp_valid), .rev_resp_ready(rev_resp_ready),
    .rev_resp_hit(rev_resp_hit), .rev_resp_key(rev_resp_key),
    .lut(lut), .entry_valid(entry_valid), .count(count), .full(full)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mkey[i] = '0; mdata[i] = '0; mval[i] = 1'b0;
    end
  endtask

  task automatic model_write(input bit del, input logic [3:0] k, input logic [7:0] d, output bit err);
    int pos = -1;
    int fr  = -1;
    err = 1'b0;
    for (int i = 0; i < 4; i++) if (mval[i] && mkey[i] == k && pos < 0) pos = i;
    for (int i = 0; i < 4; i++) if (!mval[i] && fr < 0) fr = i;
    if (del) begin
      if (pos >= 0) begin mval[pos] = 1'b0; mkey[pos] = '0; mdata[pos] = '0; end
    end else if (pos >= 0) begin
      mdata[pos] = d;
    end else if (fr >= 0) begin
      mval[fr] = 1'b1; mkey[fr] = k; mdata[fr] = d;
    end else begin
      err = 1'b1;
    end
  endtask

  task automatic model_lookup(input logic [7:0] d, output bit hit, output logic [3:0] key, output int lat);
    hit = 1'b0; key = '0; lat = 4;
    for (int i = 3; i >= 0; i--) begin
      if (mval[i] && mdata[i] == d) begin hit = 1'b1; key = mkey[i]; lat = i + 1; end
    end
  endtask

  function automatic logic [47:0] exp_lut();
    logic [47:0] r = '0;
    for (int i = 0; i < 4; i++) if (mval[i]) r[i*12 +: 12] = {mkey[i], mdata[i]};
    return r;
  endfunction

  function automatic logic [3:0] exp_valid();
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = mval[i];
    return r;
  endfunction

  function automatic int exp_count();
    int n = 0;
    for (int i = 0; i < 4; i++) n += int'(mval[i]);
    return n;
  endfunction

  function automatic bit data_present(input logic [7:0] d);
    for (int i = 0; i < 4; i++) if (mval[i] && mdata[i] == d) return 1'b1;
    return 1'b0;
  endfunction

  task automatic reset_dut();
    wr_valid = 0; wr_del = 0; wr_key = 0; wr_data = 0;
    rev_req_valid = 0; rev_data = 0; rev_resp_ready = 0;
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    model_reset();
    @(negedge clk);
  endtask

  task automatic do_write(input bit del, input logic [3:0] k, input logic [7:0] d, output bit exp_e);
    int n = 0;
    exp_e = 1'b0;
    @(negedge clk);
    while (!wr_ready && n < 20) begin @(negedge clk); n++; end
    if (!wr_ready) begin
      tests++; fails++;
      $display("FAIL write_ready_timeout: wr_ready=%b required=1", wr_ready);
      return;
    end
    wr_valid = 1; wr_del = del; wr_key = k; wr_data = d;
    @(posedge clk);
    model_write(del, k, d, exp_e);
    @(negedge clk);
    wr_valid = 0; wr_del = 0;
  endtask

  task automatic do_lookup(input logic [7:0] d, input bit with_wr, input logic [3:0] wk,
                           input logic [7:0] wd, output bit tmo, output int edges);
    bit e;
    tmo = 0; edges = 0; busy_bad = 0;
    @(negedge clk);
    rev_req_valid = 1; rev_data = d;
    if (with_wr) begin wr_valid = 1; wr_del = 0; wr_key = wk; wr_data = wd; end
    @(posedge clk);
    if (with_wr) model_write(1'b0, wk, wd, e);
    @(negedge clk);
    rev_req_valid = 0; wr_valid = 0;
    if (wr_ready || rev_req_ready) busy_bad = 1;
    while (!rev_resp_valid && edges < 20) begin
      @(posedge clk); edges++;
      @(negedge clk);
      if (wr_ready || rev_req_ready) busy_bad = 1;
    end
    if (!rev_resp_valid) tmo = 1;
  endtask

  task automatic consume();
    @(negedge clk);
    rev_resp_ready = 1;
    @(posedge clk);
    @(negedge clk);
    rev_resp_ready = 0;
  endtask

  task automatic test_reset();
    wr_valid = 0; wr_del = 0; wr_key = 0; wr_data = 0;
    rev_req_valid = 0; rev_data = 0; rev_resp_ready = 0;
    rst_n = 0;
    #1;
    repeat (2) @(negedge clk);
    tests++;
    if ({lut, entry_valid, count, full, wr_err, rev_resp_valid, rev_resp_hit, rev_resp_key} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: lut=%h ev=%b cnt=%0d full=%b err=%b rv=%b hit=%b key=%h required all 0",
               lut, entry_valid, count, full, wr_err, rev_resp_valid, rev_resp_hit, rev_resp_key);
    end
    rst_n = 1;
    model_reset();
    @(negedge clk);
    tests++;
    if (wr_ready !== 1'b1 || rev_req_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready: wr_ready=%b rev_req_ready=%b required 1 1", wr_ready, rev_req_ready);
    end
  endtask

  task automatic test_insert_update();
    bit e;
    logic [3:0]  ks [3] = '{4'd3, 4'd5, 4'd3};
    logic [7:0]  ds [3] = '{8'hA1, 8'hB2, 8'hC3};
    for (int i = 0; i < 3; i++) begin
      do_write(1'b0, ks[i], ds[i], e);
      tests++;
      if (wr_err !== e || lut !== exp_lut() || entry_valid !== exp_valid()) begin
        fails++;
        $display("FAIL insert_%0d: err=%b lut=%h ev=%b required err=%b lut=%h ev=%b",
                 i, wr_err, lut, entry_valid, e, exp_lut(), exp_valid());
      end
    end
    tests++;
    if (lut[23:0] !== 24'h5B2_3C3 || entry_valid !== 4'b0011 || count !== 3'd2 || wr_err !== 1'b0) begin
      fails++;
      $display("FAIL insert_update_final: lut=%h ev=%b cnt=%0d err=%b required lut[23:0]=5b23c3 ev=0011 cnt=2 err=0",
               lut, entry_valid, count, wr_err);
    end
  endtask

  task automatic test_full();
    bit e;
    logic [47:0] snap;
    reset_dut();
    for (int k = 1; k <= 4; k++) do_write(1'b0, 4'(k), 8'($urandom_range(0, 8'h54)), e);
    tests++;
    if (full !== 1'b1 || count !== 3'd4 || lut !== exp_lut()) begin
      fails++;
      $display("FAIL fill: full=%b cnt=%0d lut=%h required full=1 cnt=4 lut=%h", full, count, lut, exp_lut());
    end
    snap = lut;
    do_write(1'b0, 4'd9, 8'($urandom), e);
    tests++;
    if (wr_err !== 1'b1 || lut !== snap || full !== 1'b1 || e !== 1'b1) begin
      fails++;
      $display("FAIL full_insert_err: err=%b lut=%h full=%b required err=1 lut=%h full=1", wr_err, lut, full, snap);
    end
    @(negedge clk);
    tests++;
    if (wr_err !== 1'b0) begin
      fails++;
      $display("FAIL err_one_cycle: err=%b required 0", wr_err);
    end
    do_write(1'b0, 4'd2, 8'h55, e);
    tests++;
    if (wr_err !== 1'b0 || lut[23:12] !== 12'h255 || lut !== exp_lut()) begin
      fails++;
      $display("FAIL full_update: err=%b lut=%h required err=0 entry1=255 lut=%h", wr_err, lut, exp_lut());
    end
  endtask

  task automatic test_delete();
    bit e;
    do_write(1'b1, 4'd2, 8'hFF, e);
    tests++;
    if (lut[23:12] !== 12'h000 || entry_valid !== 4'b1101 || count !== 3'd3 || full !== 1'b0 || wr_err !== 1'b0) begin
      fails++;
      $display("FAIL delete: entry1=%h ev=%b cnt=%0d full=%b err=%b required 000 1101 3 0 0",
               lut[23:12], entry_valid, count, full, wr_err);
    end
    do_write(1'b1, 4'd11, 8'h00, e);
    tests++;
    if (wr_err !== 1'b0 || lut !== exp_lut() || count !== 3'd3) begin
      fails++;
      $display("FAIL delete_absent: err=%b lut=%h cnt=%0d required 0 %h 3", wr_err, lut, count, exp_lut());
    end
    do_write(1'b0, 4'd7, 8'($urandom_range(0, 8'h54)), e);
    tests++;
    if (lut[23:20] !== 4'd7 || entry_valid !== 4'b1111 || lut !== exp_lut()) begin
      fails++;
      $display("FAIL reinsert_slot: lut=%h ev=%b required key7 in entry1 lut=%h ev=1111", lut, entry_valid, exp_lut());
    end
  endtask

  task automatic test_reverse_hold();
    bit e, tmo;
    int edges;
    logic [47:0] snap;
    do_write(1'b0, 4'd3, 8'h55, e);
    do_lookup(8'h55, 1'b0, 4'd0, 8'd0, tmo, edges);
    tests++;
    if (tmo || edges !== 3 || rev_resp_hit !== 1'b1 || rev_resp_key !== 4'd3 || busy_bad) begin
      fails++;
      $display("FAIL rev_hit_entry2: tmo=%b edges=%0d hit=%b key=%h busy=%b required 0 3 1 3 0",
               tmo, edges, rev_resp_hit, rev_resp_key, busy_bad);
    end
    snap = lut;
    wr_valid = 1; wr_del = 0; wr_key = 4'hE; wr_data = 8'($urandom);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      tests++;
      if (rev_resp_valid !== 1'b1 || rev_resp_hit !== 1'b1 || rev_resp_key !== 4'd3 || wr_ready !== 1'b0) begin
        fails++;
        $display("FAIL rev_hold_%0d: valid=%b hit=%b key=%h wr_ready=%b required 1 1 3 0",
                 c, rev_resp_valid, rev_resp_hit, rev_resp_key, wr_ready);
      end
    end
    wr_valid = 0;
    consume();
    tests++;
    if (rev_resp_valid !== 1'b0 || wr_ready !== 1'b1 || lut !== snap) begin
      fails++;
      $display("FAIL rev_consume: valid=%b wr_ready=%b lut=%h required 0 1 %h", rev_resp_valid, wr_ready, lut, snap);
    end
  endtask

  task automatic test_reverse_random();
    bit tmo, h;
    int edges, lat;
    logic [3:0] k;
    logic [7:0] d;
    for (int it = 0; it < 8; it++) begin
      if ($urandom_range(0, 1) == 1) d = mdata[$urandom_range(0, 3)];
      else d = 8'($urandom);
      model_lookup(d, h, k, lat);
      do_lookup(d, 1'b0, 4'd0, 8'd0, tmo, edges);
      tests++;
      if (tmo || rev_resp_hit !== h || rev_resp_key !== k || edges !== lat || busy_bad) begin
        fails++;
        $display("FAIL rev_rand_%0d d=%h: tmo=%b hit=%b key=%h edges=%0d busy=%b required hit=%b key=%h edges=%0d",
                 it, d, tmo, rev_resp_hit, rev_resp_key, edges, busy_bad, h, k, lat);
      end
      consume();
    end
  endtask

  task automatic test_miss();
    bit tmo;
    int edges;
    logic [7:0] d;
    do d = 8'($urandom); while (data_present(d));
    do_lookup(d, 1'b0, 4'd0, 8'd0, tmo, edges);
    tests++;
    if (tmo || rev_resp_hit !== 1'b0 || rev_resp_key !== 4'd0 || edges !== 4) begin
      fails++;
      $display("FAIL rev_miss: tmo=%b hit=%b key=%h edges=%0d required 0 0 0 4", tmo, rev_resp_hit, rev_resp_key, edges);
    end
    consume();
  endtask

  task automatic test_same_edge();
    bit e, tmo, h;
    int edges, lat;
    logic [3:0] k;
    logic [7:0] d;
    do_write(1'b1, 4'd1, 8'd0, e);
    do d = 8'($urandom); while (data_present(d));
    do_lookup(d, 1'b1, 4'hB, d, tmo, edges);
    model_lookup(d, h, k, lat);
    tests++;
    if (tmo || rev_resp_hit !== 1'b1 || rev_resp_key !== 4'hB || edges !== 1 || rev_resp_key !== k || lut !== exp_lut()) begin
      fails++;
      $display("FAIL same_edge: tmo=%b hit=%b key=%h edges=%0d lut=%h required 1 b 1 lut=%h",
               tmo, rev_resp_hit, rev_resp_key, edges, lut, exp_lut());
    end
    consume();
  endtask

  task automatic test_random_writes();
    bit e, del;
    logic [3:0] k;
    logic [7:0] d;
    for (int it = 0; it < 40; it++) begin
      del = ($urandom_range(0, 2) == 0);
      k = 4'($urandom_range(0, 7));
      d = 8'($urandom);
      do_write(del, k, d, e);
      tests++;
      if (wr_err !== e || lut !== exp_lut() || entry_valid !== exp_valid() ||
          count !== 3'(exp_count()) || full !== (exp_count() == 4)) begin
        fails++;
        $display("FAIL rand_wr_%0d del=%b k=%h: err=%b lut=%h ev=%b cnt=%0d full=%b required err=%b lut=%h ev=%b cnt=%0d",
                 it, del, k, wr_err, lut, entry_valid, count, full, e, exp_lut(), exp_valid(), exp_count());
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    bit seen = 0;
    @(negedge clk);
    rev_req_valid = 1; rev_data = 8'($urandom);
    @(posedge clk);
    @(negedge clk);
    rev_req_valid = 0;
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    tests++;
    if ({lut, entry_valid, count, full, wr_err, rev_resp_valid, rev_resp_hit, rev_resp_key} !== '0) begin
      fails++;
      $display("FAIL midscan_reset: lut=%h ev=%b cnt=%0d full=%b err=%b rv=%b hit=%b key=%h required all 0",
               lut, entry_valid, count, full, wr_err, rev_resp_valid, rev_resp_hit, rev_resp_key);
    end
    @(negedge clk);
    rst_n = 1;
    model_reset();
    #1;
    tests++;
    if (wr_ready !== 1'b1) begin
      fails++;
      $display("FAIL midscan_ready: wr_ready=%b required 1", wr_ready);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rev_resp_valid !== 1'b0) seen = 1;
    end
    tests++;
    if (seen) begin
      fails++;
      $display("FAIL midscan_no_resp: rev_resp_valid seen=1 required 0");
    end
  endtask

  initial begin
    test_reset();
    test_insert_update();
    test_full();
    test_delete();
    test_reverse_hold();
    test_reverse_random();
    test_miss();
    test_same_edge();
    test_random_writes();
    test_reverse_random();
    test_reset_mid_scan();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
